// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a 256K x 16 asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYC strobe cycles) -> HOLD, with all pins registered.
module sram_port_arbiter #(
    parameter int WAIT_CYC = 8,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16
) (
    input  logic              SRAM_sys_clk,
    input  logic              SRAM_rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [DATA_W-1:0] SRAM_DB_O,
    output logic              SRAM_DB_OE,
    input  logic [DATA_W-1:0] SRAM_DB_I,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                sel_q, sel_d;
    logic                we_q, we_d;
    logic [1:0]          be_q, be_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   dbo_q, dbo_d;
    logic                dboe_q, dboe_d;
    logic                we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d;
    logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
    logic                win;

    // Port 1 wins when it is alone, or when both request and port 0 was served last.
    assign win = p1_req & (~p0_req | ~last_gnt_q);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        sel_d      = sel_q;
        we_d       = we_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        dbo_d      = dbo_q;
        dboe_d     = dboe_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        ce_n_d     = ce_n_q;
        ub_n_d     = ub_n_q;
        lb_n_d     = lb_n_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        case (state_q)
            IDLE: begin
                if (p0_req | p1_req) begin
                    sel_d      = win;
                    last_gnt_d = win;
                    we_d       = win ? p1_we : p0_we;
                    be_d       = win ? p1_be : p0_be;
                    a_d        = win ? p1_addr : p0_addr;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    ce_n_d     = 1'b0;
                    if (win ? p1_we : p0_we) begin
                        dbo_d  = win ? p1_wdata : p0_wdata;
                        dboe_d = 1'b1;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (we_q) begin
                    we_n_d = 1'b0;
                    ub_n_d = ~be_q[1];
                    lb_n_d = ~be_q[0];
                end else begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end
                cnt_d   = 4'd0;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    we_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    // Read data is taken while OE_N is still low, on the strobe's last edge.
                    if (!we_q) begin
                        if (sel_q) rd1_d = SRAM_DB_I;
                        else       rd0_d = SRAM_DB_I;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                dboe_d  = 1'b0;
                ce_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                done0_d = ~sel_q;
                done1_d = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SRAM_sys_clk) begin
        if (SRAM_rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            cnt_q      <= 4'd0;
            a_q        <= '0;
            dbo_q      <= '0;
            dboe_q     <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            be_q       <= be_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            dbo_q      <= dbo_d;
            dboe_q     <= dboe_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            ce_n_q     <= ce_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    assign p0_gnt      = gnt0_q;
    assign p1_gnt      = gnt1_q;
    assign p0_done     = done0_q;
    assign p1_done     = done1_q;
    assign p0_rdata    = rd0_q;
    assign p1_rdata    = rd1_q;
    assign SRAM_A      = a_q;
    assign SRAM_DB_O   = dbo_q;
    assign SRAM_DB_OE  = dboe_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_UB_N   = ub_n_q;
    assign SRAM_LB_N   = lb_n_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed accesses against a byte-lane SRAM model,
// completion scoreboard plus strobe-timing monitor.
module tb_sram_port_arbiter;
  localparam int WAIT_CYC = 8;
  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
  logic [1:0]        p0_be = '0, p1_be = '0;
  logic              p0_gnt, p0_done, p1_gnt, p1_done;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_dbo, sram_dbi;
  logic              sram_dboe, we_n, oe_n, ce_n, ub_n, lb_n;
  logic [1:0]        dbg_state;

  sram_port_arbiter #(.WAIT_CYC(WAIT_CYC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .SRAM_sys_clk(clk), .SRAM_rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .SRAM_A(sram_a), .SRAM_DB_O(sram_dbo), .SRAM_DB_OE(sram_dboe), .SRAM_DB_I(sram_dbi),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .dbg_state_o(dbg_state)
  );

  // SRAM model: byte-lane writes while WE_N low, data returned while OE_N low
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (!ce_n && !we_n && sram_dboe) begin
      if (!ub_n) mem[sram_a][15:8] <= sram_dbo[15:8];
      if (!lb_n) mem[sram_a][7:0]  <= sram_dbo[7:0];
    end
  end
  assign sram_dbi = (!ce_n && !oe_n) ? mem[sram_a] : '0;

  // scoreboard state: entry = {port, we, expected rdata}
  logic [DATA_W+1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic [ADDR_W-1:0] exp_a = '0;
  logic [1:0]        exp_lanes = 2'b11;
  logic              chk_a = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // completion monitor
  always @(posedge clk) begin
    logic [DATA_W+1:0] e;
    #1;
    if (!rst && (p0_done || p1_done)) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: p0_done=%0b p1_done=%0b with empty queue (t=%0t)",
                 p0_done, p1_done, $time);
      end else begin
        e = exp_q.pop_front();
        chk("done_port", {31'b0, p1_done}, {31'b0, e[DATA_W+1]});
        if (!e[DATA_W]) chk("rdata", {16'b0, (p1_done ? p1_rdata : p0_rdata)}, {16'b0, e[DATA_W-1:0]});
      end
    end
  end

  // strobe timing / bus turnaround monitor
  logic we_n_p = 1'b1, oe_n_p = 1'b1, dboe_p = 1'b0;
  int   we_len = 0, oe_len = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      we_n_p = 1'b1; oe_n_p = 1'b1; dboe_p = 1'b0; we_len = 0; oe_len = 0;
    end else begin
      if (!oe_n) chk("dboe_while_oe", {31'b0, sram_dboe}, 32'd0);
      if (we_n_p && !we_n) begin
        chk("wr_setup_dboe", {31'b0, dboe_p}, 32'd1);
        chk("wr_lanes", {30'b0, ub_n, lb_n}, {30'b0, exp_lanes});
        if (chk_a) chk("wr_addr", {14'b0, sram_a}, {14'b0, exp_a});
      end
      if (!we_n_p && we_n) begin
        chk("we_width", we_len, WAIT_CYC);
        chk("wr_hold_dboe", {31'b0, sram_dboe}, 32'd1);
        if (chk_a) chk("wr_hold_addr", {14'b0, sram_a}, {14'b0, exp_a});
        we_len = 0;
      end
      if (oe_n_p && !oe_n) begin
        chk("rd_lanes", {30'b0, ub_n, lb_n}, 32'd0);
        if (chk_a) chk("rd_addr", {14'b0, sram_a}, {14'b0, exp_a});
      end
      if (!oe_n_p && oe_n) begin
        chk("oe_width", oe_len, WAIT_CYC);
        oe_len = 0;
      end
      if (!we_n) we_len++;
      if (!oe_n) oe_len++;
      we_n_p = we_n; oe_n_p = oe_n; dboe_p = sram_dboe;
    end
  end

  // driver: one single-port access with latency checks
  task automatic issue(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input logic [1:0] be, input logic [DATA_W-1:0] rd);
    int cyc;
    @(negedge clk);
    exp_a = addr; exp_lanes = ~be; chk_a = 1'b1;
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_be = be; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_be = be; end
    exp_q.push_back({port, we, rd});
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(port ? p1_gnt : p0_gnt) && cyc < 20);
    chk("gnt_latency", cyc, 1);
    p0_req = 0; p1_req = 0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(port ? p1_done : p0_done) && cyc < 40);
    chk("done_latency", cyc, WAIT_CYC + 2);
  endtask

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int cyc, last_t, done_before;
    repeat (3) @(negedge clk);
    chk("rst_addr", {14'b0, sram_a}, 32'd0);
    chk("rst_dbo", {16'b0, sram_dbo}, 32'd0);
    chk("rst_dboe", {31'b0, sram_dboe}, 32'd0);
    chk("rst_strobes", {27'b0, we_n, oe_n, ce_n, ub_n, lb_n}, 32'h1f);
    chk("rst_gnt_done", {28'b0, p0_gnt, p1_gnt, p0_done, p1_done}, 32'd0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    rst = 0;

    issue(0, 1'b1, 18'h00005, 16'hAA55, 2'b11, 16'h0000);
    issue(1, 1'b0, 18'h00005, 16'h0000, 2'b00, 16'hAA55);
    issue(1, 1'b1, 18'h3FFFF, 16'h1234, 2'b01, 16'h0000);
    issue(0, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'h0034);

    // both ports requesting continuously from reset
    @(negedge clk);
    rst = 1; chk_a = 1'b0;
    p0_req = 1; p0_we = 0; p0_addr = 18'h00005;
    p1_req = 1; p1_we = 0; p1_addr = 18'h3FFFF;
    for (int g = 0; g < 4; g++) exp_q.push_back({g[0], 1'b0, (g[0] ? 16'h0034 : 16'hAA55)});
    repeat (2) @(negedge clk);
    rst = 0;
    cyc = 0; last_t = 0;
    for (int g = 0; g < 4; g++) begin
      do begin @(negedge clk); cyc++; end while (!(p0_gnt || p1_gnt) && cyc < 100);
      chk("rr_single_gnt", {31'b0, p0_gnt & p1_gnt}, 32'd0);
      chk("rr_order", {31'b0, p1_gnt}, {31'b0, g[0]});
      if (g > 0) chk("rr_spacing", cyc - last_t, WAIT_CYC + 3);
      last_t = cyc;
    end
    p0_req = 0; p1_req = 0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 60) begin @(negedge clk); cyc++; end
    chk("rr_drained", exp_q.size(), 0);

    // reset during the 4th ACCESS cycle of a p0 read
    @(negedge clk);
    exp_a = 18'h00005; chk_a = 1'b1;
    p0_req = 1; p0_we = 0; p0_addr = 18'h00005;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!p0_gnt && cyc < 20);
    chk("abort_gnt_latency", cyc, 1);
    p0_req = 0;
    done_before = n_done;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_strobes", {29'b0, we_n, oe_n, ce_n}, 32'h7);
    chk("abort_dboe", {31'b0, sram_dboe}, 32'd0);
    chk("abort_rdata", {16'b0, p0_rdata}, 32'd0);
    rst = 0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", n_done - done_before, 0);
    issue(1, 1'b0, 18'h00005, 16'h0000, 2'b00, 16'hAA55);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
